// File: rtl/intc_prio.sv
// 8-line priority interrupt controller: edge capture, masked pending, in-service nesting, vector address.
// Optional macro INTC_SYNC_EN inserts a 2-flop synchroniser on every irq_in bit.
module intc_prio #(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3F0,
    parameter int                VEC_STRIDE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        irq_in,
    input  logic              mask_we,
    input  logic [7:0]        mask_in,
    input  logic [7:0]        s_calli,
    input  logic [7:0]        s_reti,
    input  logic              lost_clr,
    output logic [7:0]        max_bit_s,
    output logic [7:0]        max_bit_a,
    output logic [ADDR_W-1:0] vec_addr,
    output logic [7:0]        pending,
    output logic [7:0]        irq_lost
);

    logic [7:0]        irq_s;
    logic [7:0]        irq_q_r;
    logic [7:0]        pend_r;
    logic [7:0]        isr_r;
    logic [7:0]        lost_r;
    logic [7:0]        mask_r;

    logic [7:0]        edge_s;
    logic [7:0]        pend_nxt_s;
    logic [7:0]        isr_nxt_s;
    logic [7:0]        lost_nxt_s;
    logic [7:0]        mask_nxt_s;
    logic [7:0]        req_s;
    logic [7:0]        hp_s;
    logic [7:0]        act_s;
    logic [7:0]        sel_s;
    logic [2:0]        sel_idx_s;
    logic [ADDR_W-1:0] vec_s;

    // One-hot of the most significant set bit; zero when nothing is set.
    function automatic logic [7:0] msb_onehot(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = 8'h01 << i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Bit index of a one-hot vector; zero for an all-zero vector.
    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

`ifdef INTC_SYNC_EN
    logic [7:0] sync1_r;
    logic [7:0] sync2_r;

    // Two-stage synchroniser for asynchronous interrupt lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
        end
    end

    assign irq_s = sync2_r;
`else
    assign irq_s = irq_in;
`endif

    // Next-state for pending/in-service/lost/mask and the priority selection.
    always_comb begin
        edge_s     = irq_s & ~irq_q_r;
        // A fresh edge beats a same-cycle call so the new request survives.
        pend_nxt_s = (pend_r & ~s_calli) | edge_s;
        if (lost_clr) begin
            lost_nxt_s = edge_s & pend_r;
        end else begin
            lost_nxt_s = lost_r | (edge_s & pend_r);
        end
        isr_nxt_s  = (isr_r & ~s_reti) | s_calli;
        if (mask_we) begin
            mask_nxt_s = mask_in;
        end else begin
            mask_nxt_s = mask_r;
        end

        req_s = pend_r & mask_r;
        hp_s  = msb_onehot(req_s);
        act_s = msb_onehot(isr_r);
        // Only a strictly higher request pre-empts the active line.
        if (hp_s > act_s) begin
            sel_s = hp_s;
        end else begin
            sel_s = act_s;
        end
        sel_idx_s = onehot_index(sel_s);
        vec_s     = VEC_BASE + ADDR_W'(sel_idx_s) * ADDR_W'(VEC_STRIDE);
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q_r <= 8'h00;
            pend_r  <= 8'h00;
            isr_r   <= 8'h00;
            lost_r  <= 8'h00;
            mask_r  <= 8'hFF;
        end else begin
            irq_q_r <= irq_s;
            pend_r  <= pend_nxt_s;
            isr_r   <= isr_nxt_s;
            lost_r  <= lost_nxt_s;
            mask_r  <= mask_nxt_s;
        end
    end

    assign max_bit_s = sel_s;
    assign max_bit_a = act_s;
    assign vec_addr  = vec_s;
    assign pending   = pend_r;
    assign irq_lost  = lost_r;

endmodule

// File: tb/tb_intc_prio.sv
// Scoreboard bench for intc_prio: directed stimulus pushes expectations, a negedge monitor compares.
`timescale 1ns/1ps
module tb_intc_prio;

`ifdef INTC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [9:0] VB = 10'h3F0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_in;
    logic [7:0] s_calli;
    logic [7:0] s_reti;
    logic       lost_clr;
    logic [7:0] max_bit_s;
    logic [7:0] max_bit_a;
    logic [9:0] vec_addr;
    logic [7:0] pending;
    logic [7:0] irq_lost;

    intc_prio dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .s_calli   (s_calli),
        .s_reti    (s_reti),
        .lost_clr  (lost_clr),
        .max_bit_s (max_bit_s),
        .max_bit_a (max_bit_a),
        .vec_addr  (vec_addr),
        .pending   (pending),
        .irq_lost  (irq_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] s;
        logic [7:0] a;
        logic [9:0] v;
        logic [7:0] p;
        logic [7:0] l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cmp(input string nm, input string fld, input logic [9:0] act, input logic [9:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %h expected %h (t=%0t)", nm, fld, act, want, $time);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            mon_e = sb.pop_front();
            cmp(mon_e.nm, "max_bit_s", {2'b00, max_bit_s}, {2'b00, mon_e.s});
            cmp(mon_e.nm, "max_bit_a", {2'b00, max_bit_a}, {2'b00, mon_e.a});
            cmp(mon_e.nm, "vec_addr",  vec_addr,           mon_e.v);
            cmp(mon_e.nm, "pending",   {2'b00, pending},   {2'b00, mon_e.p});
            cmp(mon_e.nm, "irq_lost",  {2'b00, irq_lost},  {2'b00, mon_e.l});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [7:0] s, input logic [7:0] a,
                              input logic [9:0] v, input logic [7:0] p, input logic [7:0] l);
        exp_t e;
        e.cyc = cyc_cnt;
        e.nm  = nm;
        e.s   = s;
        e.a   = a;
        e.v   = v;
        e.p   = p;
        e.l   = l;
        sb.push_back(e);
    endtask

    // Edge on lines x; c / lc are applied on the edge where the request reaches pending.
    task automatic fire_x(input logic [7:0] x, input logic [7:0] c, input logic lc);
        irq_in = x;
        for (int i = 0; i < LAT; i++) begin
            if (i == LAT - 1) begin
                s_calli  = c;
                lost_clr = lc;
            end
            tick();
            irq_in = 8'h00;
        end
        s_calli  = 8'h00;
        lost_clr = 1'b0;
        tick();
    endtask

    task automatic fire(input logic [7:0] x);
        fire_x(x, 8'h00, 1'b0);
    endtask

    task automatic calli(input logic [7:0] c);
        s_calli = c;
        tick();
        s_calli = 8'h00;
    endtask

    task automatic reti(input logic [7:0] r);
        s_reti = r;
        tick();
        s_reti = 8'h00;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_in = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic clr_lost();
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        irq_in   = 8'h00;
        mask_we  = 1'b0;
        mask_in  = 8'hFF;
        s_calli  = 8'h00;
        s_reti   = 8'h00;
        lost_clr = 1'b0;
        tick();
        tick();
        expect_now("reset", 8'h00, 8'h00, VB, 8'h00, 8'h00);
        reset = 1'b1;
        tick();

        // Request latency on line 6
        irq_in = 8'h40;
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_now($sformatf("lat%0d", i), (i >= LAT) ? 8'h40 : 8'h00, 8'h00,
                       (i >= LAT) ? VB + 10'd12 : VB, (i >= LAT) ? 8'h40 : 8'h00, 8'h00);
        end
        irq_in = 8'h00;
        tick();
        calli(8'h40);
        reti(8'h40);
        expect_now("lat_clean", 8'h00, 8'h00, VB, 8'h00, 8'h00);

        // Basic request / enter / exit
        fire(8'h04);
        expect_now("basic_req", 8'h04, 8'h00, VB + 10'd4, 8'h04, 8'h00);
        calli(8'h04);
        expect_now("basic_call", 8'h04, 8'h04, VB + 10'd4, 8'h00, 8'h00);
        reti(8'h04);
        expect_now("basic_reti", 8'h00, 8'h00, VB, 8'h00, 8'h00);
        reti(8'h80);
        expect_now("reti_idle", 8'h00, 8'h00, VB, 8'h00, 8'h00);

        // Nesting
        calli(8'h04);
        expect_now("nest_in2", 8'h04, 8'h04, VB + 10'd4, 8'h00, 8'h00);
        fire(8'h20);
        expect_now("nest_req5", 8'h20, 8'h04, VB + 10'd10, 8'h20, 8'h00);
        calli(8'h20);
        expect_now("nest_in5", 8'h20, 8'h20, VB + 10'd10, 8'h00, 8'h00);
        fire(8'h02);
        expect_now("nest_req1", 8'h20, 8'h20, VB + 10'd10, 8'h02, 8'h00);
        reti(8'h20);
        expect_now("nest_ret5", 8'h04, 8'h04, VB + 10'd4, 8'h02, 8'h00);
        reti(8'h04);
        expect_now("nest_ret2", 8'h02, 8'h00, VB + 10'd2, 8'h02, 8'h00);
        calli(8'h02);
        reti(8'h02);
        expect_now("nest_clean", 8'h00, 8'h00, VB, 8'h00, 8'h00);

        // Mask
        write_mask(8'hFE);
        fire(8'h01);
        expect_now("mask_hide", 8'h00, 8'h00, VB, 8'h01, 8'h00);
        write_mask(8'hFF);
        expect_now("mask_open", 8'h01, 8'h00, VB, 8'h01, 8'h00);
        calli(8'h01);
        reti(8'h01);
        expect_now("mask_clean", 8'h00, 8'h00, VB, 8'h00, 8'h00);

        // Simultaneous edge and call, lost tracking
        fire_x(8'h08, 8'h08, 1'b0);
        expect_now("simul", 8'h08, 8'h08, VB + 10'd6, 8'h08, 8'h00);
        fire(8'h08);
        expect_now("lost_set", 8'h08, 8'h08, VB + 10'd6, 8'h08, 8'h08);
        clr_lost();
        expect_now("lost_clr", 8'h08, 8'h08, VB + 10'd6, 8'h08, 8'h00);
        fire_x(8'h08, 8'h00, 1'b1);
        expect_now("lost_wins", 8'h08, 8'h08, VB + 10'd6, 8'h08, 8'h08);
        clr_lost();
        calli(8'h08);
        reti(8'h08);
        expect_now("simul_clean", 8'h00, 8'h00, VB, 8'h00, 8'h00);

        // Asynchronous reset mid-service
        calli(8'h80);
        calli(8'h01);
        fire(8'h10);
        expect_now("pre_reset", 8'h80, 8'h80, VB + 10'd14, 8'h10, 8'h00);
        tick();
        reset = 1'b0;
        expect_now("async_reset", 8'h00, 8'h00, VB, 8'h00, 8'h00);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_now($sformatf("post_reset%0d", i), 8'h00, 8'h00, VB, 8'h00, 8'h00);
        end

        tick();
        tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intc_prio.md
Name: intc_prio

Overview:
- 8-line priority interrupt controller that feeds the control unit.
- Detects rising edges on external IRQ lines, holds them pending under a mask, and tracks nesting with an in-service register.
- Drives max_bit_s (selected one-hot) and max_bit_a (active one-hot) into the control unit, and consumes its s_calli / s_reti strobes.
- Also supplies the vector address the PC mux takes when s_inc = 2'b10.

Parameters:
- ADDR_W, 10, width of program-counter / vector address.
- VEC_BASE, 10'h3F0, vector address of line 0.
- VEC_STRIDE, 2, address distance between consecutive line vectors (power of two).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  8  external interrupt lines; bit 7 is highest priority.
- mask_we  in  1  load mask register from mask_in.
- mask_in  in  8  new mask; 1 = line enabled.
- s_calli  in  8  one-hot of the line being entered (from the control unit); 0 = none.
- s_reti  in  8  one-hot of the line being exited (from the control unit); 0 = none.
- lost_clr  in  1  clear irq_lost.
- max_bit_s  out  8  one-hot of highest selected request (pending, unmasked, or active).
- max_bit_a  out  8  one-hot of highest in-service line; 0 = none.
- vec_addr  out  ADDR_W  VEC_BASE + index(max_bit_s) * VEC_STRIDE; VEC_BASE when max_bit_s = 0.
- pending  out  8  raw pending register, for debug.
- irq_lost  out  8  sticky: an edge arrived while that line was already pending.

Behaviour:
- Reset (reset = 0, asynchronous) clears all registers:
  - pending = 0, in-service = 0, irq_lost = 0, mask = 8'hFF, edge-detect/sync flops = 0.
  - Outputs are therefore max_bit_s = 0, max_bit_a = 0, vec_addr = VEC_BASE.
  - Reset mid-service discards all nesting state; no vector is output after release until a new edge arrives.
- Edge detect: irq_q registers the (optionally synchronised) irq_in. edge[i] = irq_s[i] & ~irq_q[i]. Level-high lines never re-trigger.
- Pending update per bit, each clock:
  - edge sets the bit.
  - s_calli[i] clears the bit.
  - If edge and s_calli hit the same bit in the same cycle, set wins (the new request is not lost).
  - An edge while pending[i] is already 1 sets irq_lost[i].
  - lost_clr clears all of irq_lost. If lost_clr and a new loss occur in the same cycle, the loss wins.
- In-service (isr) update per bit: s_reti[i] clears the bit and s_calli[i] sets it.
  - Both in the same cycle on different bits: both apply.
  - Both on the same bit: set wins.
  - s_reti on a line not in service: no effect.
  - s_calli on a line not pending: in-service is still set.
- Mask: registered on mask_we, effective the next cycle. Masked lines keep accumulating pending but are invisible to selection. Unmasking releases the line immediately in combinational output.
- Selection (combinational from registers):
  - req = pending & mask.
  - hp = one-hot of the highest set bit of req.
  - max_bit_a = one-hot of the highest set bit of isr.
  - max_bit_s = hp if hp > max_bit_a (unsigned compare), else max_bit_a.
  - Result: the control unit sees max_bit_s > max_bit_a only for a strictly higher-priority request. This gives nesting; equal or lower requests wait.
- Latency without sync: irq_in rising before clock edge k → pending set at edge k → max_bit_s valid during cycle k+1.
- Selection must stay stable while the control unit holds s_calli. Pending clear and isr set happen at the same edge, so after that edge max_bit_s == max_bit_a for the entered line.
- No wrap-around or counting: 8 nesting levels maximum, one per line.

Optional Feature:
- Macro INTC_SYNC_EN.
- Defined: each irq_in bit passes through a 2-flop synchroniser (reset to 0) before edge detect. Request latency becomes 3 edges, so max_bit_s is valid in cycle k+3.
- Undefined: irq_in feeds edge detect directly (irq_s = irq_in). Inputs must be synchronous to clk; latency as above.

Test Plan:
- Reset, then irq_in = 8'h04 pulse → pending = 8'h04, max_bit_s = 8'h04, max_bit_a = 0, vec_addr = VEC_BASE+4. Then s_calli = 8'h04 for 1 cycle → pending = 0, max_bit_s = max_bit_a = 8'h04. Then s_reti = 8'h04 → all 0.
- Nesting: line 2 in service; edge on line 5 → max_bit_s = 8'h20, vec_addr = VEC_BASE+10. Call line 5, then edge on line 1 → max_bit_s stays 8'h20 with pending = 8'h02. Reti 5 → max_bit_s = 8'h04. Reti 2 → max_bit_s = 8'h02.
- Mask: mask = 8'hFE, edge on line 0 → pending = 8'h01, max_bit_s = 0. Write mask = 8'hFF → max_bit_s = 8'h01 the next cycle.
- Simultaneous: s_calli = 8'h08 in the same cycle as a new edge on line 3 → pending[3] = 1 and isr[3] = 1, so max_bit_s = max_bit_a = 8'h08. A second edge while still pending → irq_lost = 8'h08. lost_clr → 0.
- Reset asserted while isr = 8'h81 and pending = 8'h10 → all outputs 0 and vec_addr = VEC_BASE immediately, without waiting for a clock edge.
- With INTC_SYNC_EN: irq_in[6] rises → max_bit_s = 8'h40 exactly 3 edges later, not 1.
